// File: rtl/core_pkg.sv
// Shared definitions for the forwarding/hazard scoreboard.
// Holds the register address width, the EX forward select encodings
// and the per-stage scoreboard slot record.
package core_pkg;

    localparam int REG_AW = 5;

    // EX operand forward selects: the value is the slot index it reads from
    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              is_load;
        logic [REG_AW-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Producer search for one source register across all scoreboard slots.
// Ports:
//   slots     in   scoreboard contents, slot0=EX .. slot DEPTH-1=WB
//   src       in   source register being looked up
//   used      in   source is actually read by the instruction
//   branch    in   instruction compares its operands in ID
//   sel       out  youngest producing slot at index >= 1, 0 if none
//   sel_ready out  that producer can forward now (1 when there is none)
//   hazard    out  instruction holding this source must stall in ID
//   mem_fwd   out  MEM slot produces src and its value is ready
module fwd_match
    import core_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = 2
) (
    input  sb_entry_t [DEPTH-1:0] slots,
    input  logic [REG_AW-1:0]     src,
    input  logic                  used,
    input  logic                  branch,
    output logic [SELW-1:0]       sel,
    output logic                  sel_ready,
    output logic                  hazard,
    output logic                  mem_fwd
);

    logic [DEPTH-1:0] prod;
    logic             early_load;

    // A load result only becomes forwardable LOAD_LAT stages after EX
    function automatic logic rdy(input sb_entry_t e, input int j);
        return ~e.is_load | (j >= 1 + LOAD_LAT);
    endfunction

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            prod[j] = slots[j].valid & slots[j].reg_write
                    & (slots[j].rd == src) & (src != '0);
        end
    end

    // Scan oldest to youngest so the youngest producer overrides
    always_comb begin
        sel       = SELW'(FWD_RF);
        sel_ready = 1'b1;
        for (int j = DEPTH - 1; j >= 1; j--) begin
            if (used && prod[j]) begin
                sel       = SELW'(j);
                sel_ready = rdy(slots[j], j);
            end
        end
    end

    always_comb begin
        early_load = 1'b0;
        for (int j = 1; j <= LOAD_LAT && j < DEPTH; j++) begin
            early_load = early_load | (prod[j] & slots[j].is_load);
        end
        hazard = used & ((prod[0] & slots[0].is_load)
                       | (branch & prod[0])
                       | (branch & early_load));
    end

    assign mem_fwd = used & prod[FWD_MEM]
                   & rdy(slots[FWD_MEM], FWD_MEM);

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit: tracks in-flight writers in a shift scoreboard.
// Ports:
//   clk, rst                         clock, async active-high reset
//   id_valid/rd/reg_write/is_load    ID instruction description
//   id_is_branch                     ID compares operands (beq/bne)
//   id_rs, id_rs_used                ID sources, operand k at [k*REG_AW +: REG_AW]
//   flush_i                          discard the ID instruction
//   stall_o                          hold PC and IF/ID, bubble into EX
//   fwd_ex_sel                       per EX operand slot select (0 = regfile)
//   fwd_id                           per ID branch operand take MEM ALU result
//   stall_cnt                        saturating count of stall cycles
module fwd_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_is_load,
    input  logic                   id_is_branch,
    input  logic [NSRC*REG_AW-1:0] id_rs,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic [NSRC*$clog2(DEPTH+1)-1:0] fwd_ex_sel,
    output logic [NSRC-1:0]        fwd_id,
    output logic [CNT_W-1:0]       stall_cnt
);

    import core_pkg::*;

    localparam int SELW = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0]         slots;
    logic [NSRC-1:0][REG_AW-1:0]   ex_rs;
    logic [NSRC-1:0]               ex_rs_used;

    logic [NSRC-1:0][SELW-1:0]     ex_sel;
    logic [NSRC-1:0]               ex_rdy;
    logic [NSRC-1:0]               ex_haz;
    logic [NSRC-1:0]               ex_mem;
    logic [NSRC-1:0][SELW-1:0]     id_sel;
    logic [NSRC-1:0]               id_rdy;
    logic [NSRC-1:0]               id_haz;
    logic [NSRC-1:0]               id_mem;
    logic                          admit;
    logic                          unused_match;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        // EX operand lookup for the instruction sitting in slot0
        fwd_match #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SELW     (SELW)
        ) u_ex (
            .slots     (slots),
            .src       (ex_rs[k]),
            .used      (slots[0].valid & ex_rs_used[k]),
            .branch    (1'b0),
            .sel       (ex_sel[k]),
            .sel_ready (ex_rdy[k]),
            .hazard    (ex_haz[k]),
            .mem_fwd   (ex_mem[k])
        );

        // ID operand lookup: hazards and branch-compare forwarding
        fwd_match #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SELW     (SELW)
        ) u_id (
            .slots     (slots),
            .src       (id_rs[k*REG_AW +: REG_AW]),
            .used      (id_rs_used[k]),
            .branch    (id_is_branch),
            .sel       (id_sel[k]),
            .sel_ready (id_rdy[k]),
            .hazard    (id_haz[k]),
            .mem_fwd   (id_mem[k])
        );

        // An unready producer is never forwarded; fall back to the regfile
        assign fwd_ex_sel[k*SELW +: SELW] =
            ex_rdy[k] ? ex_sel[k] : SELW'(FWD_RF);
    end

    assign unused_match = ^{ex_haz, ex_mem, id_sel, id_rdy};

    // Flush wins over any hazard
    assign stall_o = id_valid & ~flush_i & (|id_haz);
    assign fwd_id  = {NSRC{id_valid & id_is_branch}} & id_mem;
    assign admit   = id_valid & ~stall_o & ~flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots      <= '0;
            ex_rs      <= '0;
            ex_rs_used <= '0;
            stall_cnt  <= '0;
        end else begin
            for (int j = 1; j < DEPTH; j++) begin
                slots[j] <= slots[j-1];
            end
            if (admit) begin
                slots[0] <= '{valid:     1'b1,
                              reg_write: id_reg_write,
                              is_load:   id_is_load,
                              rd:        id_rd};
                ex_rs      <= id_rs;
                ex_rs_used <= id_rs_used;
            end else begin
                slots[0]   <= '0;
                ex_rs_used <= '0;
            end
            if (stall_o && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    // A correct stall never lets a not-yet-ready load reach the EX select
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NSRC; k++) begin
                assert (!(slots[0].valid && ex_rs_used[k] && !ex_rdy[k]))
                    else $error("EX operand %0d needs an unready load", k);
            end
        end
    end

endmodule
